// File: rtl/sram_word_bridge.sv
// sram_word_bridge: splits each 32-bit MEM-stage load/store into two 16-bit SRAM controller accesses, low half first (optional SRAM_BRIDGE_LAST_READ_EN read buffer).
// Latency: 10 cycles per access (freeze high 9 cycles, released in DONE); a buffer hit answers a repeat load in 0 cycles.
// Backpressure: freeze holds the pipeline until DONE; each half waits on controller ready after its issue cycle.
module sram_word_bridge #(
    parameter logic [31:0] ADDR_BASE = 32'd1024
) (
    input  logic        Clock_50,
    input  logic        Resetn,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_write_data,
    output logic [31:0] MEM_read_data,
    output logic        freeze,
    output logic        mem_op,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    input  logic        SRAM_ready,
    input  logic [15:0] SRAM_read_data
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t      state_q, state_d;
    logic        issued_q;
    logic [15:0] lo_q;
    logic [31:0] rd_q;
    logic [31:0] off;
    logic [16:0] widx;
    logic        req;
    logic        advance;
    logic        hit;
    logic        unused_off;

    assign off        = mem_address - ADDR_BASE;
    assign widx       = off[18:2];
    assign unused_off = ^{off[31:19], off[1:0]};
    assign req        = MEM_R_EN | MEM_W_EN;
    // ready is still high from the previous half in the issue cycle, so it only counts once issued
    assign advance    = issued_q & SRAM_ready;

`ifdef SRAM_BRIDGE_LAST_READ_EN
    logic        buf_vld_q;
    logic [16:0] buf_tag_q;
    logic [31:0] buf_dat_q;

    assign hit = (state_q == IDLE) & MEM_R_EN & ~MEM_W_EN & buf_vld_q & (buf_tag_q == widx);
    assign MEM_read_data = hit ? buf_dat_q : rd_q;

    always_ff @(posedge Clock_50) begin
        if (Resetn) begin
            buf_vld_q <= 1'b0;
            buf_tag_q <= '0;
            buf_dat_q <= '0;
        end else if (state_q == IDLE && state_d == LO && MEM_W_EN) begin
            buf_vld_q <= 1'b0;
        end else if (state_q == HI && advance && !MEM_W_EN) begin
            buf_vld_q <= 1'b1;
            buf_tag_q <= widx;
            buf_dat_q <= {SRAM_read_data, lo_q};
        end
    end
`else
    assign hit = 1'b0;
    assign MEM_read_data = rd_q;
`endif

    always_comb begin
        state_d         = state_q;
        mem_op          = 1'b0;
        SRAM_address    = '0;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        freeze          = req & (state_q != DONE) & ~hit;
        case (state_q)
            IDLE: begin
                if (req && !hit) state_d = LO;
            end
            LO: begin
                mem_op          = 1'b1;
                SRAM_address    = {widx, 1'b0};
                SRAM_we_n       = ~MEM_W_EN;
                SRAM_write_data = MEM_W_EN ? mem_write_data[15:0] : 16'h0;
                if (advance) state_d = HI;
            end
            HI: begin
                mem_op          = 1'b1;
                SRAM_address    = {widx, 1'b1};
                SRAM_we_n       = ~MEM_W_EN;
                SRAM_write_data = MEM_W_EN ? mem_write_data[31:16] : 16'h0;
                if (advance) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock_50) begin
        if (Resetn) begin
            state_q  <= IDLE;
            issued_q <= 1'b0;
            lo_q     <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            issued_q <= (state_q == LO || state_q == HI) && !advance;
            if (state_q == LO && advance && !MEM_W_EN) lo_q <= SRAM_read_data;
            if (state_q == HI && advance && !MEM_W_EN) rd_q <= {SRAM_read_data, lo_q};
        end
    end

endmodule

// File: tb/tb_sram_word_bridge.sv
// Bench for sram_word_bridge: negedge SRAM controller stand-in plus a word-level reference memory.
// Random loads/stores are checked for latency, per-half bus contents and assembled load data.
`timescale 1ns/1ps
module tb_sram_word_bridge;

    localparam logic [31:0] BASE = 32'd1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r_en = 1'b0;
    logic        w_en = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdat = '0;
    logic [31:0] rd;
    logic        frz;
    logic        mop;
    logic [17:0] sa;
    logic [15:0] swd;
    logic        we_n;
    logic        srdy = 1'b1;
    logic [15:0] srd;

    sram_word_bridge #(.ADDR_BASE(BASE)) dut (
        .Clock_50       (clk),
        .Resetn         (rst),
        .MEM_R_EN       (r_en),
        .MEM_W_EN       (w_en),
        .mem_address    (addr),
        .mem_write_data (wdat),
        .MEM_read_data  (rd),
        .freeze         (frz),
        .mem_op         (mop),
        .SRAM_address   (sa),
        .SRAM_write_data(swd),
        .SRAM_we_n      (we_n),
        .SRAM_ready     (srdy),
        .SRAM_read_data (srd)
    );

    always #5 clk = ~clk;

    // Controller stand-in: ready drops in the first cycle of a half, rises in the fourth.
    logic [15:0] sram [64];
    int          ccnt = 0;

    always @(negedge clk) begin
        if (!mop) begin
            srdy <= 1'b1;
            ccnt <= 0;
        end else if (ccnt == 3) begin
            srdy <= 1'b1;
            ccnt <= 0;
            if (!we_n) sram[sa[5:0]] <= swd;
        end else begin
            if (ccnt == 0) srdy <= 1'b0;
            ccnt <= ccnt + 1;
        end
    end

    assign srd = (srdy && we_n) ? sram[sa[5:0]] : 16'h0;

    // Reference model: whole 32-bit words, last load result, last-read buffer.
    logic [31:0] ref_mem [32];
    logic [31:0] last_rd = '0;
    bit          buf_vld = 0;
    int          buf_k   = 0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic access(input bit wr, input int k, input logic [31:0] wd);
        int   cyc;
        int   exp_lat;
        bit   hit;
        logic half;
        hit = 0;
`ifdef SRAM_BRIDGE_LAST_READ_EN
        hit = !wr && buf_vld && (buf_k == k);
`endif
        exp_lat = hit ? 0 : 9;
        @(posedge clk); #1;
        w_en = wr;
        r_en = !wr || ($urandom_range(0, 1) == 1);
        addr = BASE + 32'(k * 4) + $urandom_range(0, 3);
        wdat = wd;
        #1;
        cyc = 0;
        while (frz && cyc < 40) begin
            if (cyc == 0) begin
                check_eq("mem_op_cycle0", 32'(mop), 32'd0);
            end else begin
                half = (cyc >= 5);
                check_eq("mem_op_busy", 32'(mop), 32'd1);
                check_eq("sram_addr", 32'(sa), 32'({k[16:0], half}));
                check_eq("sram_we_n", 32'(we_n), 32'(!wr));
                check_eq("sram_wdata", 32'(swd),
                         wr ? (half ? 32'(wd[31:16]) : 32'(wd[15:0])) : 32'd0);
            end
            @(posedge clk); #2;
            cyc++;
        end
        check_eq(hit ? "latency_hit" : "latency", cyc, exp_lat);
        check_eq("mem_op_done", 32'(mop), 32'd0);
        if (wr) begin
            ref_mem[k] = wd;
            buf_vld    = 0;
        end else begin
            last_rd = ref_mem[k];
            buf_vld = 1;
            buf_k   = k;
        end
        check_eq(wr ? "rdata_after_store" : "load_data", rd, last_rd);
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        r_en = 1'b0;
        w_en = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) sram[i] = 16'h0;
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_eq("rst_rdata", rd, 32'h0);
        check_eq("rst_mem_op", 32'(mop), 32'd0);
        check_eq("rst_we_n", 32'(we_n), 32'd1);
        check_eq("rst_freeze", 32'(frz), 32'd0);
        check_eq("rst_sram_addr", 32'(sa), 32'd0);
        check_eq("rst_sram_wdata", 32'(swd), 32'd0);

        access(1, 2, 32'hDEADBEEF);
        idle(2);
        access(0, 2, 32'h0);
        access(0, 2, 32'h0);
        access(1, 2, 32'h12345678);
        access(0, 2, 32'h0);
        access(1, 3, 32'hA5A50F0F);
        access(1, 7, 32'h0BADF00D);
        idle(1);
        access(0, 3, 32'h0);
        access(0, 7, 32'h0);

        // Reset pulsed in cycle 6 of a load.
        @(posedge clk); #1;
        r_en = 1'b1;
        w_en = 1'b0;
        addr = BASE + 32'd20;
        repeat (6) @(posedge clk);
        #1;
        rst  = 1'b1;
        r_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_eq("midrst_mem_op", 32'(mop), 32'd0);
        check_eq("midrst_freeze", 32'(frz), 32'd0);
        check_eq("midrst_rdata", rd, 32'h0);
        last_rd = '0;
        buf_vld = 0;
        access(0, 7, 32'h0);

        for (int i = 0; i < 40; i++) begin
            access($urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
